// File: rtl/varredor_tabela_pkg.sv
// Shared types and constants for the truth-table scanner.
// State encoding, default expected table and mismatch-index helper.
package varredor_tabela_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FIM    = 2'd3
  } estado_t;

  localparam logic [7:0] ESPERADO_PADRAO = 8'h63;

  // Lowest set bit position, 0 when no bit is set.
  function automatic logic [2:0] menor_bit(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/varredor_tabela_contador.sv
// Settling-time counter for the scanner.
// Cleared to zero by i_clr, counts on i_en, flags the last wait cycle.
module contador_espera (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [3:0] i_lim,
  output logic       o_tc
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_tc = (r_cnt == i_lim - 4'd1);

endmodule

// File: rtl/varredor_tabela.sv
// Truth-table scanner: walks {A,B,C} through 0..7, samples S,
// and compares the captured table with the expected one.
module varredor_tabela
  import varredor_tabela_pkg::*;
#(
  parameter int         SETTLE   = 2,
  parameter logic [7:0] ESPERADO = ESPERADO_PADRAO
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       S,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic [7:0] tabela,
  output logic       ok,
  output logic [2:0] erro_idx
);

  localparam logic [3:0] LIM = 4'(SETTLE);

  estado_t    r_estado;
  estado_t    w_prox;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic [2:0] r_abc;
  logic [7:0] r_tabela;
  logic [7:0] w_tab_nxt;
  logic       r_ok;
  logic [2:0] r_erro;
  logic       w_tc;
  logic       w_busy;
  logic       w_done;
  logic       w_cnt_clr;
  logic       w_cnt_en;
  logic       w_aceita;
  logic       w_captura;
  logic       w_fim_scan;

  contador_espera u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .i_lim (LIM),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= IDLE;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      IDLE:   if (start) w_prox = DRIVE;
      DRIVE:  if (w_tc) w_prox = SAMPLE;
      SAMPLE: w_prox = (r_idx == 3'd7) ? FIM : DRIVE;
      FIM:    w_prox = start ? DRIVE : IDLE;
      default: w_prox = IDLE;
    endcase
  end

  // FIM accepts start too, so a held start chains scans back to back.
  always_comb begin
    w_busy     = (r_estado == DRIVE) || (r_estado == SAMPLE);
    w_done     = (r_estado == FIM);
    w_cnt_en   = (r_estado == DRIVE);
    w_cnt_clr  = (r_estado != DRIVE);
    w_captura  = (r_estado == SAMPLE);
    w_aceita   = start && ((r_estado == IDLE) || (r_estado == FIM));
    w_fim_scan = w_captura && (r_idx == 3'd7);
  end

  always_comb begin
    w_tab_nxt = r_tabela;
    w_idx_nxt = r_idx;
    if (w_aceita) begin
      w_tab_nxt = '0;
      w_idx_nxt = '0;
    end else if (w_captura) begin
      w_tab_nxt[r_idx] = S;
      if (r_idx != 3'd7) w_idx_nxt = r_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_abc    <= '0;
      r_tabela <= '0;
      r_ok     <= 1'b0;
      r_erro   <= '0;
    end else begin
      r_idx    <= w_idx_nxt;
      r_tabela <= w_tab_nxt;
      if ((w_prox == DRIVE) || (w_prox == SAMPLE))
        r_abc <= w_idx_nxt;
      else
        r_abc <= '0;
      if (w_fim_scan) begin
        r_ok   <= (w_tab_nxt == ESPERADO);
        r_erro <= menor_bit(w_tab_nxt ^ ESPERADO);
      end
    end
  end

  assign {A, B, C} = r_abc;
  assign busy      = w_busy;
  assign done      = w_done;
  assign tabela    = r_tabela;
  assign ok        = r_ok;
  assign erro_idx  = r_erro;

endmodule

// File: doc/varredor_tabela.md
VARREDOR_TABELA -- requirements
Module: varredor_tabela

Interface
REQ-001 Parameter SETTLE, default 2: wait cycles per input combination before S is sampled; legal range 1..15.
REQ-002 Parameter ESPERADO, default 8'h63: expected table; bit i = expected S for {A,B,C}=i.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  scan request, sampled on rising edge.
REQ-006 S  input  1  response of the 3-input function under test.
REQ-007 A, B, C  output  1 each  stimulus bits; A is MSB of the index.
REQ-008 busy  output  1  high while a scan is in progress.
REQ-009 done  output  1  one-cycle pulse when a scan completes.
REQ-010 tabela  output  8  captured table; bit i = S sampled for index i.
REQ-011 ok  output  1  high when the last completed scan gave tabela == ESPERADO.
REQ-012 erro_idx  output  3  lowest index where tabela differs from ESPERADO; 0 when ok.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, SAMPLE and FIM.
REQ-014 IDLE: start=1 SHALL move to DRIVE and set idx=0, wait counter=0, busy=1 and tabela=0.
REQ-015 {A,B,C} SHALL be registered copies of idx while in DRIVE and SAMPLE; they SHALL be 3'b000 in IDLE and FIM.
REQ-016 DRIVE SHALL count SETTLE cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle.
REQ-018 On the clock edge that leaves SAMPLE, S SHALL be written into tabela[idx].
REQ-019 On leaving SAMPLE, idx<7 SHALL increment idx, clear the counter and return to DRIVE.
REQ-020 On leaving SAMPLE, idx=7 SHALL go to FIM.
REQ-021 Each index SHALL therefore be held SETTLE+1 cycles, and a full scan SHALL take 8*(SETTLE+1) cycles in DRIVE/SAMPLE.
REQ-022 FIM SHALL last one cycle: done=1, busy=0, ok and erro_idx updated; then return to IDLE.
REQ-023 In FIM, ok SHALL equal (tabela == ESPERADO), and erro_idx SHALL be the lowest set bit index of (tabela XOR ESPERADO), or 0 if there is none.
REQ-024 tabela, ok and erro_idx SHALL hold their values in IDLE until the next accepted start.
REQ-025 start while busy=1 SHALL be ignored, with no restart and no queueing.
REQ-026 start held high continuously SHALL start back-to-back scans, each beginning on the cycle after FIM.
REQ-027 idx SHALL never wrap past 7 within a scan.
REQ-028 The wait counter SHALL be 4 bits wide and SHALL never overflow for legal SETTLE.
REQ-029 Changes on S outside the SAMPLE capture edge SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL immediately force the state to IDLE and all outputs to 0: A, B, C, busy, done, tabela, ok, erro_idx.
REQ-031 rst_n=0 SHALL also clear idx and the wait counter.
REQ-032 Reset mid-scan SHALL abort the scan with no done pulse.
REQ-033 The first scan after reset release SHALL need a fresh start.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, FIM=2'd3) and the default table constant 8'h63.
REQ-035 One sub-module, contador_espera (a 4-bit loadable wait counter with a terminal-count flag), is natural; everything else SHALL live in varredor_tabela.

Verification
REQ-036 Scan of the correct function (S = f(A,B,C) per table 8'h63), SETTLE=2, start pulse -> done 24 cycles after DRIVE entry, tabela=8'h63, ok=1, erro_idx=0.
REQ-037 S tied to 1 -> tabela=8'hFF, ok=0, erro_idx=2.
REQ-038 S = function with index 5 inverted -> tabela=8'h43, ok=0, erro_idx=5.
REQ-039 start re-pulsed at index 3 of a running scan -> scan continues unchanged, exactly one done pulse, result as REQ-036.
REQ-040 rst_n low at index 4 -> outputs 0 immediately, no done pulse; next start gives a full correct scan.
REQ-041 start held high for two scans with SETTLE=1 -> two done pulses 17 cycles apart, A,B,C = 000 on the FIM cycles.
